// File: rtl/ir_cmd_pkg.sv
// Shared types and defaults for the IR command decoder slice.
package ir_cmd_pkg;

  // Control FSM states; encodings are visible on the fsm_state port.
  typedef enum logic [1:0] {
    ST_STOP    = 2'd0,
    ST_SEEK    = 2'd1,
    ST_REQ     = 2'd2,
    ST_HOLDOFF = 2'd3
  } ir_fsm_e;

  // Default per-command color masks, command 0 in the LSBs:
  // cmd0=000, cmd1=101, cmd2=011, cmd3=110.
  localparam logic [11:0] IR_CMD_DEFAULT_MASKS = 12'hCE8;

endpackage

// File: rtl/ir_debounce.sv
// IR command debouncer: validates the active-low one-hot bus, tracks a
// candidate code with a saturating stability counter and latches cmd_id.
// o_upd/o_upd_cmd expose the latch decision combinationally so the parent
// FSM can react on the same edge cmd_id changes.
module ir_debounce
  import ir_cmd_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  localparam int unsigned CW             = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic [NUM_CH-1:0] i_ir_n,
  output logic [CW-1:0]     o_cmd_id,
  output logic              o_cmd_changed,
  output logic              o_upd,
  output logic [CW-1:0]     o_upd_cmd
);

  localparam logic [15:0] LP_DEB = 16'(DEBOUNCE_CYCLES);

  logic [CW-1:0] r_cand;
  logic [15:0]   r_cnt;
  logic [CW-1:0] r_cmd;
  logic          r_chg;

  logic          w_valid;
  logic [CW-1:0] w_code;
  logic [15:0]   w_cnt_next;
  logic          w_upd;

  assign w_valid = $onehot(~i_ir_n);

  // Index of the low line; only meaningful when exactly one line is low.
  always_comb begin
    w_code = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!i_ir_n[i]) w_code = CW'(i);
    end
  end

  // Next stability count: restart on a new code, otherwise saturating increment.
  always_comb begin
    if (w_code != r_cand)     w_cnt_next = 16'd1;
    else if (r_cnt == LP_DEB) w_cnt_next = r_cnt;
    else                      w_cnt_next = r_cnt + 16'd1;
  end

  assign w_upd = i_enable & w_valid & (w_cnt_next == LP_DEB) & (w_code != r_cmd);

  // Candidate, counter and latched command; everything holds while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_cmd  <= '0;
      r_chg  <= 1'b0;
    end else if (!i_enable) begin
      r_chg <= 1'b0;
    end else begin
      r_chg <= w_upd;
      if (!w_valid) begin
        r_cnt <= '0;
      end else begin
        r_cand <= w_code;
        r_cnt  <= w_cnt_next;
        if (w_upd) r_cmd <= w_code;
      end
    end
  end

  assign o_cmd_id      = r_cmd;
  assign o_cmd_changed = r_chg;
  assign o_upd         = w_upd;
  assign o_upd_cmd     = w_code;

endmodule

// File: rtl/ir_command_decoder.sv
// IR command decoder top: debounced command, color-mask match and the
// pickup request/acknowledge FSM toward the arm controller.
// Optional ack timeout: define IR_CMD_ACK_TIMEOUT_EN to abandon a request
// after ACK_TIMEOUT cycles in REQ; otherwise REQ waits indefinitely.
module ir_command_decoder
  import ir_cmd_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned NUM_COLORS      = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLDOFF_CYCLES  = 64,
  parameter logic [NUM_CH*NUM_COLORS-1:0] CMD_MASKS = IR_CMD_DEFAULT_MASKS,
  parameter int unsigned ACK_TIMEOUT     = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ir_n,
  input  logic [NUM_COLORS-1:0]     color,
  input  logic                      pickup_ack,
  output logic [$clog2(NUM_CH)-1:0] cmd_id,
  output logic                      cmd_changed,
  output logic [1:0]                ir_state,
  output logic                      pickup_req,
  output logic [1:0]                fsm_state,
  output logic                      timeout
);

  localparam int unsigned CW = $clog2(NUM_CH);
  localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HW-1:0] LP_HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  logic [CW-1:0]         w_cmd;
  logic                  w_chg;
  logic                  w_upd;
  logic [CW-1:0]         w_upd_cmd;
  logic [NUM_COLORS-1:0] w_mask;
  logic                  w_match;

  ir_fsm_e               r_state;
  logic                  r_req;
  logic                  r_match;
  logic [HW-1:0]         r_hold_cnt;

  ir_debounce #(
    .NUM_CH          (NUM_CH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk           (clk),
    .reset         (reset),
    .i_enable      (enable),
    .i_ir_n        (ir_n),
    .o_cmd_id      (w_cmd),
    .o_cmd_changed (w_chg),
    .o_upd         (w_upd),
    .o_upd_cmd     (w_upd_cmd)
  );

  assign w_mask  = CMD_MASKS[w_cmd*NUM_COLORS +: NUM_COLORS];
  assign w_match = |(color & w_mask);

`ifdef IR_CMD_ACK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] LP_TO_LAST = TW'(ACK_TIMEOUT - 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  // Pickup FSM; a command latch on this edge overrides every state action,
  // including a coincident pickup_ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_STOP;
      r_req      <= 1'b0;
      r_match    <= 1'b0;
      r_hold_cnt <= '0;
`ifdef IR_CMD_ACK_TIMEOUT_EN
      r_to_cnt   <= '0;
      r_timeout  <= 1'b0;
`endif
    end else if (enable) begin
      r_match <= w_match;
`ifdef IR_CMD_ACK_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      if (w_upd) begin
        r_req      <= 1'b0;
        r_hold_cnt <= '0;
        r_state    <= (w_upd_cmd == '0) ? ST_STOP : ST_SEEK;
      end else begin
        unique case (r_state)
          ST_STOP: r_state <= ST_STOP;
          ST_SEEK: begin
            if (r_match) begin
              r_state <= ST_REQ;
              r_req   <= 1'b1;
`ifdef IR_CMD_ACK_TIMEOUT_EN
              r_to_cnt <= '0;
`endif
            end
          end
          ST_REQ: begin
            if (pickup_ack) begin
              r_state    <= ST_HOLDOFF;
              r_req      <= 1'b0;
              r_hold_cnt <= '0;
            end
`ifdef IR_CMD_ACK_TIMEOUT_EN
            else if (r_to_cnt == LP_TO_LAST) begin
              r_state   <= ST_SEEK;
              r_req     <= 1'b0;
              r_timeout <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
`endif
          end
          ST_HOLDOFF: begin
            if (r_hold_cnt == LP_HOLD_LAST) r_state <= ST_SEEK;
            else                            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        endcase
      end
    end else begin
`ifdef IR_CMD_ACK_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end
  end

  assign cmd_id      = w_cmd;
  assign cmd_changed = w_chg;
  assign ir_state    = {(w_cmd != '0), r_match & ((r_state == ST_SEEK) | (r_state == ST_REQ))};
  assign pickup_req  = r_req;
  assign fsm_state   = r_state;

endmodule

// File: doc/ir_command_decoder.md
Name: ir_command_decoder

Overview:
- Parametrised successor to the 4-code IR instruction decoder.
- Decodes a NUM_CH-wide active-low one-hot IR receiver bus into a debounced command, and matches the live color-sensor vector against a per-command color mask.
- Drives a pickup request/acknowledge handshake toward the arm controller.
- Sits between the IR front-end / color sensor and the drive/arm control FSMs.

Parameters:
- NUM_CH, 4, number of IR command channels; command 0 is always STOP.
- NUM_COLORS, 3, width of the color-detect vector.
- DEBOUNCE_CYCLES, 16, consecutive enabled cycles a code must be stable before it is latched; legal range 1 to 2^16-1.
- HOLDOFF_CYCLES, 64, cooldown after an acknowledged pickup before re-arming; legal range ≥1.
- CMD_MASKS, 12'hCE8, packed NUM_CH*NUM_COLORS color masks, command 0 in the LSBs. Default values: cmd0=000, cmd1=101, cmd2=011, cmd3=110.
- ACK_TIMEOUT, 1024, cycles to wait for pickup_ack. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  when low, debouncer and FSM hold all state
- ir_n  in  NUM_CH  active-low one-hot IR channel lines
- color  in  NUM_COLORS  color-detected flags, one bit per color
- pickup_ack  in  1  arm controller accepted the pickup
- cmd_id  out  $clog2(NUM_CH)  current latched command
- cmd_changed  out  1  one-cycle pulse when cmd_id updates
- ir_state  out  2  bit1 = command active (cmd_id≠0); bit0 = registered color match
- pickup_req  out  1  pickup request, level-held until ack
- fsm_state  out  2  STOP=0, SEEK=1, REQ=2, HOLDOFF=3
- timeout  out  1  one-cycle pulse on ack timeout; tied 0 when the optional feature is compiled out

Behaviour:
- Reset: all outputs 0; FSM in STOP; debounce counter 0; candidate code 0.
- Code decode: code is valid only when exactly one ir_n bit is low. The code is the index of that bit.
- Invalid patterns (all high, or multiple lows) reset the debounce counter. cmd_id is retained.
- Debounce:
  - A valid code differing from the held candidate loads the candidate and sets the counter to 1.
  - The same code on the next cycle increments the counter.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, cmd_id takes the candidate and cmd_changed pulses.
  - Latency from first stable sample to cmd_id update is DEBOUNCE_CYCLES edges.
  - A code equal to the current cmd_id never pulses cmd_changed. The counter saturates.
- Match: match = |(color & CMD_MASKS[cmd_id]). ir_state[0] is the registered match while in SEEK or REQ, and 0 otherwise.
- FSM transitions:
  - STOP → SEEK when cmd_id becomes nonzero.
  - SEEK → REQ on the cycle after match is sampled high. pickup_req rises with the REQ entry.
  - REQ → HOLDOFF on pickup_ack. pickup_req drops in the same edge.
  - HOLDOFF counts HOLDOFF_CYCLES, then goes to SEEK.
- Any state → STOP on the edge cmd_id becomes 0. pickup_req drops immediately.
- A nonzero command change in REQ or HOLDOFF → SEEK. Any pending request is dropped and the holdoff counter is cleared.
- pickup_ack outside REQ is ignored.
- Simultaneous command change and pickup_ack in REQ: the command change wins and the ack is ignored.
- enable low: no counter, FSM or output change. pickup_req holds its level. cmd_changed and timeout are forced 0.
- reset mid-REQ: pickup_req drops on that edge and the FSM returns to STOP.

Optional Feature:
- IR_CMD_ACK_TIMEOUT_EN defined: a counter runs in REQ. After ACK_TIMEOUT cycles without ack, the block pulses timeout, drops pickup_req and returns to SEEK.
- Undefined: REQ waits indefinitely and timeout is tied to 0.

Decomposition:
- Package ir_cmd_pkg holds the FSM state enum (STOP/SEEK/REQ/HOLDOFF) and the default CMD_MASKS constant.
- Sub-module ir_debounce contains the one-hot validation, candidate register, counter and cmd_id/cmd_changed outputs.
- The match logic and FSM stay in the top level.

Test Plan:
- Reset, then ir_n=4'b1101 held 16 cycles → cmd_id=1 on the 16th edge, one cmd_changed pulse, fsm_state=SEEK. Held 15 cycles then 4'b1111 → cmd_id stays 0.
- cmd 1, color=3'b100 → pickup_req high 2 edges later. pickup_ack pulse → pickup_req low, fsm_state=HOLDOFF for 64 cycles, then SEEK.
- cmd 2 (mask 011), color=3'b100 → no request. color=3'b010 → request.
- In REQ, drive ir_n=4'b1110 stable 16 cycles → cmd_id=0, fsm_state=STOP, pickup_req low on the same edge.
- Glitch test: ir_n=4'b1001 (two lows) interleaved with 4'b1011 → counter restarts and cmd_id is unchanged until 16 clean cycles.
- IR_CMD_ACK_TIMEOUT_EN defined, REQ with no ack for 1024 cycles → timeout pulse, pickup_req low, SEEK. enable low for 100 cycles mid-REQ → no timeout and state frozen.
